// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: latches request edges as pending bits and grants
// one pending line at a time, fixed-priority or round-robin, over valid/ready.
//
// Parameters:
//   N          number of request lines (N >= 2, any value)
//   W          index width, derived from N
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        request lines, a 0->1 transition posts a request
//   mask       1 = line not selectable (its pending bit still latches)
//   mode       0 = highest index wins, 1 = round-robin
//   out_ready  consumer accepts out_idx
//   out_valid  out_idx holds a granted request
//   out_idx    binary index of the granted line, always < N
//   pending    latched requests not yet granted
//   drop       1-cycle pulse: a new edge merged into an already pending bit
module irq_priority_encoder #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         drop
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] req_q;
  logic [N-1:0] pend_q, pend_d;
  logic         vld_q, vld_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] last_q, last_d;
  logic         drop_q, drop_d;

  logic [N-1:0] edge_v;
  logic [N-1:0] clr_v;
  logic [N-1:0] elig;
  logic         hs;
  logic [W-1:0] fix_idx;
  logic [W-1:0] rr_idx;

  // Request edge detection and handshake-driven clear of the granted bit.
  assign edge_v = req & ~req_q;
  assign hs     = vld_q & out_ready;
  assign clr_v  = hs ? ({{(N-1){1'b0}}, 1'b1} << idx_q) : '0;
  assign elig   = pend_q & ~mask;

  // A new edge wins over a same-cycle clear so the fresh request survives.
  always_comb begin
    pend_d = (pend_q & ~clr_v) | edge_v;
    drop_d = |(edge_v & pend_q & ~clr_v);
  end

  // Fixed priority: ascending scan, so the highest eligible index
  // is the last one written.
  always_comb begin
    fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (elig[W'(i)]) begin
        fix_idx = W'(i);
      end
    end
  end

  // Round-robin: walk offsets N..1 downward from last grant so the
  // smallest offset (nearest successor) is the last one written.
  // Offset N lands on last grant itself, the final fallback.
  always_comb begin
    int j;
    rr_idx = '0;
    for (int k = N; k >= 1; k--) begin
      j = int'(last_q) + k;
      if (j >= N) begin
        j = j - N;
      end
      if (elig[W'(j)]) begin
        rr_idx = W'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          idx_d   = mode ? rr_idx : fix_idx;
          vld_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Grant is frozen here; mask/mode/req
        // cannot disturb it until accepted.
        if (out_ready) begin
          vld_d   = 1'b0;
          last_d  = idx_q;
          state_d = IDLE;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Last grant resets to N-1 so the first round-robin scan starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      pend_q <= '0;
      vld_q  <= 1'b0;
      idx_q  <= '0;
      last_q <= W'(N - 1);
      drop_q <= 1'b0;
    end else begin
      req_q  <= req;
      pend_q <= pend_d;
      vld_q  <= vld_d;
      idx_q  <= idx_d;
      last_q <= last_d;
      drop_q <= drop_d;
    end
  end

  assign out_valid = vld_q;
  assign out_idx   = idx_q;
  assign pending   = pend_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// tb_irq_priority_encoder: directed vectors with expected grants queued
// by stimulus and consumed by independent handshake monitors.
module tb_irq_priority_encoder;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         mode;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] pending;
  logic         drop;

  logic [4:0]   req5;
  logic [4:0]   mask5;
  logic         mode5;
  logic         rdy5;
  logic         vld5;
  logic [2:0]   idx5;
  logic [4:0]   pend5;
  logic         drop5;

  int checks = 0;
  int errors = 0;
  int drop_cnt = 0;
  int q[$];
  int q5[$];

  always #5 clk = ~clk;

  irq_priority_encoder #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mask      (mask),
    .mode      (mode),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pending   (pending),
    .drop      (drop)
  );

  irq_priority_encoder #(.N(5)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req5),
    .mask      (mask5),
    .mode      (mode5),
    .out_ready (rdy5),
    .out_valid (vld5),
    .out_idx   (idx5),
    .pending   (pend5),
    .drop      (drop5)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    req       = '0;
    mask      = '0;
    mode      = 1'b0;
    out_ready = 1'b0;
    req5      = '0;
    mask5     = '0;
    mode5     = 1'b0;
    rdy5      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor, N=8 instance.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grant_unexpected: got idx %0d expected none",
                 out_idx);
      end else begin
        int e;
        e = q.pop_front();
        chk("grant_idx", int'(out_idx), e);
      end
    end
  end

  // Scoreboard monitor, N=5 instance.
  always @(negedge clk) begin
    if (rst_n && vld5 && rdy5) begin
      chk("n5_idx_range", int'(idx5 < 3'd5), 1);
      if (q5.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL n5_grant_unexpected: got idx %0d expected none",
                 idx5);
      end else begin
        int e;
        e = q5.pop_front();
        chk("n5_grant_idx", int'(idx5), e);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && drop) drop_cnt++;
  end

  initial begin
    int seen;
    do_reset();

    // Reset state
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_idx", int'(out_idx), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_drop", int'(drop), 0);

    // T1 fixed priority, multi-hot 0x05
    q.push_back(2);
    q.push_back(0);
    mode      = 1'b0;
    out_ready = 1'b1;
    req       = 8'h05;
    cyc(10);
    chk("t1_drained", q.size(), 0);
    chk("t1_pending", int'(pending), 0);
    chk("t1_valid", int'(out_valid), 0);

    // T2 round-robin, all lines
    do_reset();
    for (int i = 0; i < 8; i++) q.push_back(i);
    mode      = 1'b1;
    out_ready = 1'b1;
    req       = 8'hFF;
    cyc(15);
    @(negedge clk);
    #1;
    chk("t2_rate_left1", q.size(), 1);
    @(negedge clk);
    #1;
    chk("t2_rate_left0", q.size(), 0);
    cyc(6);
    chk("t2_pending", int'(pending), 0);
    chk("t2_valid", int'(out_valid), 0);

    // T3 masked line
    do_reset();
    mask = 8'h08;
    req  = 8'h08;
    cyc(1);
    req  = 8'h00;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (out_valid) seen = 1;
    end
    chk("t3_blocked", seen, 0);
    chk("t3_pending", int'(pending), 8'h08);
    q.push_back(3);
    mask = 8'h00;
    cyc(2);
    chk("t3_valid", int'(out_valid), 1);
    chk("t3_idx", int'(out_idx), 3);
    out_ready = 1'b1;
    cyc(3);
    chk("t3_drained", q.size(), 0);
    chk("t3_pending0", int'(pending), 0);

    // T4 grant frozen in hold
    do_reset();
    req = 8'h02;
    q.push_back(1);
    q.push_back(6);
    cyc(2);
    chk("t4_valid", int'(out_valid), 1);
    chk("t4_idx", int'(out_idx), 1);
    req  = 8'h42;
    mask = 8'h02;
    mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("t4_hold", int'(out_valid && out_idx == 3'd1), 1);
    end
    chk("t4_pending", int'(pending), 8'h42);
    mask      = 8'h00;
    mode      = 1'b0;
    out_ready = 1'b1;
    cyc(6);
    chk("t4_drained", q.size(), 0);
    chk("t4_pending0", int'(pending), 0);

    // T5 re-edges on a pending line merge and pulse drop
    do_reset();
    drop_cnt = 0;
    q.push_back(4);
    req = 8'h10; cyc(1);
    req = 8'h00; cyc(1);
    req = 8'h10; cyc(1);
    req = 8'h00; cyc(1);
    req = 8'h10; cyc(1);
    req = 8'h00; cyc(2);
    chk("t5_drops", drop_cnt, 2);
    chk("t5_pending", int'(pending), 8'h10);
    out_ready = 1'b1;
    cyc(6);
    chk("t5_drained", q.size(), 0);
    chk("t5_pending0", int'(pending), 0);

    // T6 async reset in hold
    do_reset();
    req = 8'h01;
    q.push_back(0);
    cyc(2);
    chk("t6_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_pending", int'(pending), 0);
    chk("t6_rst_idx", int'(out_idx), 0);
    q.delete();
    req       = 8'h00;
    out_ready = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (out_valid) seen = 1;
    end
    chk("t6_no_grant", seen, 0);

    // N=5 round-robin
    do_reset();
    for (int i = 0; i < 5; i++) q5.push_back(i);
    mode5 = 1'b1;
    rdy5  = 1'b1;
    req5  = 5'h1F;
    cyc(14);
    chk("n5_drained", q5.size(), 0);
    chk("n5_pending", int'(pend5), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
